irq_request_latch: RTL

- Front-end stage that feeds the 4-input priority encoder.
- Edge-detects N request lines and holds each detected edge as a sticky pending bit.
- Applies an enable mask, then offers the lowest-index eligible request as a stable index with a valid/ready handshake.
- Clears the served bit on acceptance and records overruns. The consumer sees one registered request at a time instead of raw levels.

---
 rtl/irq_request_latch_if.sv | 22 ++
 rtl/irq_request_latch.sv | 52 +++++
 2 files changed

// File: rtl/irq_request_latch_if.sv
// irq_request_latch_if: request, mask, clear and offer/accept handshake bundle.
interface irq_request_latch_if #(
    parameter int N    = 4,
    parameter int IDXW = 2
);
    logic [N-1:0]    req_in;
    logic [N-1:0]    mask;
    logic            clr_all;
    logic            out_ready;
    logic            out_valid;
    logic [IDXW-1:0] out_idx;
    logic [N-1:0]    pending;
    logic [N-1:0]    overrun;
    modport master (
        output req_in, mask, clr_all, out_ready,
        input  out_valid, out_idx, pending, overrun
    );
    modport slave (
        input  req_in, mask, clr_all, out_ready,
        output out_valid, out_idx, pending, overrun
    );
endinterface

// File: rtl/irq_request_latch.sv
// irq_request_latch: edge-detected sticky request latch offering the lowest eligible index over valid/ready.
module irq_request_latch #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input logic                clk,
    input logic                rst_n,
    irq_request_latch_if.slave bus
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t          state, state_d;
    logic [N-1:0]    req_q, rise, elig, served, pending_d, overrun_d;
    logic [IDXW-1:0] first_idx, out_idx_d;
    logic            accept, out_valid_d;
    assign rise      = bus.req_in & ~req_q;
    assign elig      = bus.pending & bus.mask;
    assign accept    = state == OFFER && bus.out_ready && !bus.clr_all;
    assign served    = accept ? (N'(1) << bus.out_idx) : '0;
    // a rise on the bit being served wins, so the request is kept and not counted as overrun
    assign pending_d = bus.clr_all ? '0 : rise | (bus.pending & ~served);
    assign overrun_d = bus.clr_all ? '0 : bus.overrun | (rise & bus.pending & ~served);
    always_comb begin
        first_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (elig[i]) first_idx = IDXW'(i);
    end
    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_d;
    always_comb begin
        state_d = state == IDLE ? ((|elig && !bus.clr_all) ? OFFER : IDLE)
                                : ((bus.clr_all || bus.out_ready) ? IDLE : OFFER);
    end
    always_comb begin
        out_valid_d = state_d == OFFER;
        out_idx_d   = (state == IDLE && state_d == OFFER) ? first_idx : bus.out_idx;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q         <= '0;
            bus.pending   <= '0;
            bus.overrun   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_idx   <= '0;
        end else begin
            req_q         <= bus.req_in;
            bus.pending   <= pending_d;
            bus.overrun   <= overrun_d;
            bus.out_valid <= out_valid_d;
            bus.out_idx   <= out_idx_d;
        end
    end
endmodule
